ans_table_arbiter: RTL and testbench
====================================

Name: ans_table_arbiter

Overview:
- Shares the single frequency-table read port between two requesters: port 0 is the ANS decoder and port 1 is the ANS encoder/statistics path.
- The port carries read_type, read_query and read_result, and is served by the table-holding loader.
- Grants one transaction at a time with round-robin priority and latches the type and query.
- Returns the result to the owning requester with a one-cycle done pulse.
- Includes a watchdog so that a stalled table cannot deadlock the datapath.

Parameters:
- QW, 12, query/result width (CNT_WIDTH + SYM_WIDTH = 8 + 4).
- TW, 1, read_type width (lookup by symbol vs. by cumulative count).
- TIMEOUT, 15, maximum BUSY cycles before abort; 0 disables the watchdog.
- TOW, 4, watchdog counter width; must satisfy TIMEOUT < 2^TOW.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  when low, no new grant; an in-flight transaction still completes.
- r0_req  in  1  port 0 request, held until r0_done.
- r0_type  in  TW  port 0 read type, stable while r0_req is high.
- r0_query  in  QW  port 0 query, stable while r0_req is high.
- r0_done  out  1  one-cycle completion pulse.
- r0_result  out  QW  result, valid only when r0_done is high.
- r0_err  out  1  timeout flag, valid with r0_done.
- r1_req, r1_type, r1_query, r1_done, r1_result, r1_err: identical set for port 1.
- tbl_req  out  1  table read request.
- tbl_type  out  TW  registered read_type to the table.
- tbl_query  out  QW  registered read_query to the table.
- tbl_rdy  in  1  table result valid; sampled only while tbl_req is high.
- tbl_result  in  QW  table read_result.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; owner=0; prio=0 (port 0 favoured); wdog=0. All outputs are 0, including result and type/query registers.
- Reset mid-transaction abandons it with no done pulse. Requesters must re-request after reset.
- States are IDLE, BUSY and DONE.
- IDLE: when en=1 and any req is high, select the winner:
  - both requesting: winner = prio;
  - otherwise: the single requester.
- IDLE grant actions: latch owner and the winner's type/query into tbl_type/tbl_query, set tbl_req=1, clear wdog, go to BUSY.
- IDLE with en=0 or no req: stay in IDLE.
- BUSY: tbl_req=1 and tbl_type/tbl_query are held constant.
  - tbl_rdy=1: latch tbl_result into the owner's result register, set owner's done=1, err=0, tbl_req=0, go to DONE.
  - tbl_rdy=0, TIMEOUT!=0 and wdog==TIMEOUT-1: set owner's done=1, err=1, result=0, tbl_req=0, go to DONE.
  - Otherwise: wdog += 1.
- DONE: owner's done is high for exactly this cycle; prio = ~owner; go to IDLE next cycle unconditionally. No grant is made in DONE.
- Requesters must drop req in the cycle done is seen, or a new request begins. A req still high when back in IDLE counts as a new request.
- Latency with zero-wait table (tbl_rdy in the first BUSY cycle): req seen at edge 1, tbl_req high cycle 1, done high cycle 2, IDLE cycle 3. Peak throughput is one transaction per 3 cycles.
- done/result/err for the non-owner stay 0. result registers are cleared to 0 when done deasserts.
- tbl_rdy outside BUSY is ignored.
- A req dropped while BUSY is illegal. The arbiter completes anyway and still pulses done.
- Both requests arriving in the same cycle: prio decides. Alternation is strict under continuous contention.
- en falling during BUSY: the transaction completes normally.
- Watchdog boundary: with TIMEOUT=T, err fires at the edge ending the T-th BUSY cycle. A tbl_rdy arriving in that same T-th cycle wins (err=0).

Test Plan:
- Reset, then r0_req with type=1, query=0x3A5; table returns 0x0C7 in the first BUSY cycle → tbl_query=0x3A5 in cycle 1; r0_done=1, r0_result=0x0C7, r0_err=0 in cycle 2; r1_done stays 0.
- r0 and r1 request simultaneously and continuously; table has zero wait → grants go r0, r1, r0, r1, with a done every 3 cycles; after each done the other port wins.
- Table delays tbl_rdy 4 cycles; tbl_query changes are attempted on r1_query mid-transaction → tbl_query stays at the latched value; r1_done appears in the cycle after tbl_rdy.
- TIMEOUT=15 and tbl_rdy never asserted → r0_done=1 with r0_err=1 and r0_result=0 after the 15th BUSY cycle; the next request is granted normally.
- en=0 with r1_req=1 → no tbl_req. en rises → grant next edge. en drops during BUSY → that transaction still completes.
- Assert rst during BUSY → tbl_req, busy and done go to 0 immediately; after release, r1 alone requesting is granted (priority reset to port 0 has no effect with a single requester).

Source files
------------

// File: rtl/ans_table_arbiter_if.sv
// rtl/ans_table_arbiter_if.sv - frequency-table read port shared by the ANS requesters
interface ans_table_arbiter_if #(
  parameter int QW = 12,
  parameter int TW = 1
);
  logic          tbl_req;
  logic [TW-1:0] tbl_type;
  logic [QW-1:0] tbl_query;
  logic          tbl_rdy;
  logic [QW-1:0] tbl_result;

  // Arbiter side: issues the registered request, receives the table answer
  modport master (
    output tbl_req,
    output tbl_type,
    output tbl_query,
    input  tbl_rdy,
    input  tbl_result
  );

  // Table-holding loader side
  modport slave (
    input  tbl_req,
    input  tbl_type,
    input  tbl_query,
    output tbl_rdy,
    output tbl_result
  );
endinterface

// File: rtl/ans_table_arbiter.sv
// rtl/ans_table_arbiter.sv - round-robin arbiter for the ANS frequency-table read port
module ans_table_arbiter #(
  parameter int QW      = 12,
  parameter int TW      = 1,
  parameter int TIMEOUT = 15,
  parameter int TOW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          r0_req,
  input  logic [TW-1:0] r0_type,
  input  logic [QW-1:0] r0_query,
  output logic          r0_done,
  output logic [QW-1:0] r0_result,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic [TW-1:0] r1_type,
  input  logic [QW-1:0] r1_query,
  output logic          r1_done,
  output logic [QW-1:0] r1_result,
  output logic          r1_err,
  ans_table_arbiter_if.master tbl,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last watchdog count before abort; unused when the watchdog is disabled
  localparam logic [TOW-1:0] WDOG_LAST = TOW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [TOW-1:0] wdog_q, wdog_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [QW-1:0] res_q, res_d;
  logic          req_q, req_d;
  logic [TW-1:0] type_q, type_d;
  logic [QW-1:0] query_q, query_d;
  logic          win;
  logic          wdog_expired;

  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  // State and all registered outputs; reset abandons any transaction silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      req_q   <= 1'b0;
      type_q  <= '0;
      query_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      wdog_q  <= wdog_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
      req_q   <= req_d;
      type_q  <= type_d;
      query_q <= query_d;
    end
  end

  // Next-state logic: grant in IDLE, wait/watchdog in BUSY, rotate priority in DONE
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    wdog_d  = wdog_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    res_d   = '0;
    req_d   = req_q;
    type_d  = type_q;
    query_d = query_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (r0_req || r1_req)) begin
          win     = (r0_req && r1_req) ? prio_q : r1_req;
          owner_d = win;
          type_d  = win ? r1_type : r0_type;
          query_d = win ? r1_query : r0_query;
          req_d   = 1'b1;
          wdog_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A table answer in the final watchdog cycle still wins over the abort
        if (tbl.tbl_rdy) begin
          res_d   = tbl.tbl_result;
          done_d  = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (wdog_expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + TOW'(1);
        end
      end
      DONE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tbl.tbl_req   = req_q;
  assign tbl.tbl_type  = type_q;
  assign tbl.tbl_query = query_q;
  assign busy          = (state_q != IDLE);

  // Completion is steered to the owner only; the other port sees zeros
  assign r0_done   = done_q & ~owner_q;
  assign r0_err    = err_q & ~owner_q;
  assign r0_result = owner_q ? '0 : res_q;
  assign r1_done   = done_q & owner_q;
  assign r1_err    = err_q & owner_q;
  assign r1_result = owner_q ? res_q : '0;

endmodule

// File: tb/tb_ans_table_arbiter.sv
// tb/tb_ans_table_arbiter.sv - self-checking bench for ans_table_arbiter
module tb_ans_table_arbiter;
  localparam int QW = 12;
  localparam int TW = 1;
  localparam int T  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          r0_req, r1_req;
  logic [TW-1:0] r0_type, r1_type;
  logic [QW-1:0] r0_query, r1_query;
  logic          r0_done, r1_done, r0_err, r1_err;
  logic [QW-1:0] r0_result, r1_result;
  logic          busy;

  ans_table_arbiter_if #(.QW(QW), .TW(TW)) tbl ();

  ans_table_arbiter #(.QW(QW), .TW(TW), .TIMEOUT(T), .TOW(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .r0_req(r0_req), .r0_type(r0_type), .r0_query(r0_query),
    .r0_done(r0_done), .r0_result(r0_result), .r0_err(r0_err),
    .r1_req(r1_req), .r1_type(r1_type), .r1_query(r1_query),
    .r1_done(r1_done), .r1_result(r1_result), .r1_err(r1_err),
    .tbl(tbl), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit prio_m;   // reference model: port favoured on the next contention

  typedef struct {
    bit            a, b;
    logic [QW-1:0] q0, q1;
    logic [TW-1:0] t0, t1;
    int            d;        // table wait cycles before tbl_rdy
    logic [QW-1:0] res;
    bit            ew;       // expected winner
    bit            eerr;
    int            enb;      // expected BUSY cycles
    bit            perturb;
    bit            drop_en;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction, entered right after a negedge with the DUT in IDLE
  task automatic run_txn(input bit a, input bit b, input logic [QW-1:0] q0, input logic [QW-1:0] q1,
                         input logic [TW-1:0] t0, input logic [TW-1:0] t1, input int d,
                         input logic [QW-1:0] res, input bit ew, input bit eerr, input int enb,
                         input bit perturb, input bit drop_en);
    logic [QW-1:0] exp_q;
    logic [TW-1:0] exp_t;
    logic [QW-1:0] exp_res;
    int nb;
    bit got;
    exp_q   = ew ? q1 : q0;
    exp_t   = ew ? t1 : t0;
    exp_res = eerr ? '0 : res;
    en = 1'b1;
    r0_req = a; r0_query = q0; r0_type = t0;
    r1_req = b; r1_query = q1; r1_type = t1;
    tbl.tbl_rdy = 1'b1;                      // outside BUSY this must be ignored
    tbl.tbl_result = QW'($urandom);
    @(negedge clk);
    chk("grant_tbl_req", tbl.tbl_req, 1);
    chk("grant_busy", busy, 1);
    chk("grant_query", tbl.tbl_query, exp_q);
    chk("grant_type", tbl.tbl_type, exp_t);
    nb = 0;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (r0_done || r1_done) begin
        got = 1;
        break;
      end
      nb++;
      chk("held_query", tbl.tbl_query, exp_q);
      if (perturb && nb == 2) begin
        if (ew) r1_query = ~q1; else r0_query = ~q0;
      end
      if (drop_en && nb == 1) en = 1'b0;
      if (nb == d + 1) begin
        tbl.tbl_rdy = 1'b1;
        tbl.tbl_result = res;
      end else begin
        tbl.tbl_rdy = 1'b0;
        tbl.tbl_result = QW'($urandom);
      end
      @(negedge clk);
    end
    tbl.tbl_rdy = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_cycles", nb, enb);
    chk("done_owner", ew ? r1_done : r0_done, 1);
    chk("done_other", ew ? r0_done : r1_done, 0);
    chk("result", ew ? r1_result : r0_result, exp_res);
    chk("result_other", ew ? r0_result : r1_result, 0);
    chk("err", ew ? r1_err : r0_err, eerr);
    chk("done_tbl_req", tbl.tbl_req, 0);
    if (ew) r1_req = 1'b0; else r0_req = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", r0_done | r1_done, 0);
    chk("idle_result", r0_result | r1_result, 0);
    chk("idle_no_grant", tbl.tbl_req, 0);
    prio_m = !ew;
  endtask

  initial begin
    bit a, b, w, pe, de;
    logic [1:0] pat;
    int d, enb;
    logic [QW-1:0] q0, q1, res;
    logic [TW-1:0] t0, t1;

    vecs[0] = '{1, 0, 12'h3A5, 12'h000, 1, 0,  0, 12'h0C7, 0, 0,  1, 0, 0};
    vecs[1] = '{1, 1, 12'h101, 12'h202, 0, 1,  0, 12'h0AA, 1, 0,  1, 0, 0};
    vecs[2] = '{1, 1, 12'h303, 12'h202, 1, 1,  0, 12'h0BB, 0, 0,  1, 0, 0};
    vecs[3] = '{1, 1, 12'h303, 12'h404, 0, 0,  0, 12'h0CC, 1, 0,  1, 0, 0};
    vecs[4] = '{0, 1, 12'h111, 12'h2B4, 0, 1,  4, 12'h5E6, 1, 0,  5, 1, 0};
    vecs[5] = '{1, 0, 12'h777, 12'h000, 0, 0, 30, 12'hFFF, 0, 1, 15, 0, 0};
    vecs[6] = '{1, 0, 12'h778, 12'h000, 1, 0, 14, 12'h9A9, 0, 0, 15, 0, 0};
    vecs[7] = '{1, 0, 12'h055, 12'h000, 0, 0,  2, 12'h321, 0, 0,  3, 0, 1};
    vecs[8] = '{1, 1, 12'h066, 12'h099, 0, 1,  1, 12'h456, 1, 0,  2, 0, 0};

    rst = 1'b1; en = 1'b0;
    r0_req = 0; r1_req = 0; r0_type = 0; r1_type = 0; r0_query = 0; r1_query = 0;
    tbl.tbl_rdy = 1'b0; tbl.tbl_result = '0;
    prio_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_tbl_req", tbl.tbl_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_query", tbl.tbl_query, 0);
    chk("rst_done", {r0_done, r1_done, r0_err, r1_err}, 0);
    chk("rst_result", r0_result | r1_result, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_txn(vecs[i].a, vecs[i].b, vecs[i].q0, vecs[i].q1, vecs[i].t0, vecs[i].t1, vecs[i].d,
              vecs[i].res, vecs[i].ew, vecs[i].eerr, vecs[i].enb, vecs[i].perturb, vecs[i].drop_en);

    // en low blocks grants; en high grants next edge; en dropping in BUSY is harmless
    en = 1'b0; r0_req = 0; r1_req = 1; r1_query = 12'h4D2;
    repeat (3) begin
      @(negedge clk);
      chk("en_low_tbl_req", tbl.tbl_req, 0);
      chk("en_low_busy", busy, 0);
    end
    run_txn(0, 1, 12'h000, 12'h4D2, 0, 1, 3, 12'h135, 1, 0, 4, 0, 1);

    // Reset while BUSY abandons the transaction with no done pulse
    en = 1'b1; r0_req = 1; r0_query = 12'h0F0; r1_req = 0;
    @(negedge clk);
    chk("pre_rst_tbl_req", tbl.tbl_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_tbl_req", tbl.tbl_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", r0_done | r1_done, 0);
    chk("mid_rst_query", tbl.tbl_query, 0);
    @(negedge clk);
    rst = 1'b0; r0_req = 0;
    prio_m = 0;
    run_txn(0, 1, 12'h000, 12'h6E1, 0, 0, 0, 12'h222, 1, 0, 1, 0, 0);

    // Randomized transactions against the arbitration/watchdog model
    for (int n = 0; n < 40; n++) begin
      pat = 2'($urandom_range(1, 3));
      a = pat[0]; b = pat[1];
      q0 = QW'($urandom); q1 = QW'($urandom);
      t0 = TW'($urandom); t1 = TW'($urandom);
      d = $urandom_range(0, 17);
      res = QW'($urandom);
      pe = 1'($urandom); de = 1'($urandom);
      w = (a && b) ? prio_m : b;
      enb = (d + 1 <= T) ? d + 1 : T;
      run_txn(a, b, q0, q1, t0, t1, d, res, w, (d + 1 > T), enb, pe, de);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
